// File: rtl/plic_gateway_ctrl.sv
// PLIC gateway: turns raw level/edge interrupt lines into per-source pending state,
// arbitrates claims from all targets and retires sources on complete.
module plic_gateway_ctrl #(
   parameter int N_SOURCE  = 128,
   parameter int N_TARGET  = 60,
   parameter int SRCW      = $clog2(N_SOURCE+1),
   parameter int EDGE_CNTW = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [N_SOURCE-1:0]            irq_i,
   input  logic [N_SOURCE-1:0]            le_i,
   output logic [N_SOURCE:0]              ip_o,
   output logic [N_SOURCE:0]              claimed_o,
   input  logic [N_TARGET-1:0][SRCW-1:0]  claim_id_i,
   input  logic [N_TARGET-1:0]            cc_re_i,
   output logic [N_TARGET-1:0][SRCW-1:0]  cc_id_o,
   input  logic [N_TARGET-1:0]            cc_we_i,
   input  logic [N_TARGET-1:0][SRCW-1:0]  cc_i
);

   typedef enum logic [1:0] {IDLE, PEND, CLAIMED} state_e;

   localparam logic [EDGE_CNTW-1:0] CNT_MAX = '1;

   state_e                 state_q [N_SOURCE:1];
   state_e                 state_d [N_SOURCE:1];
   logic [EDGE_CNTW-1:0]   cnt_q   [N_SOURCE:1];
   logic [EDGE_CNTW-1:0]   cnt_d   [N_SOURCE:1];
   logic [N_SOURCE-1:0]    irq_q;
   logic [N_SOURCE-1:0]    rise;
   logic [N_SOURCE:0]      ip_q, ip_d;
   logic [N_SOURCE:0]      claimed_q, claimed_d;
   logic [N_TARGET-1:0]    grant;
   logic                   taken;
   logic [N_SOURCE:1]      claim_hit;
   logic [N_SOURCE:1]      cmpl_hit;

   assign rise      = le_i & irq_i & ~irq_q;
   assign ip_o      = ip_q;
   assign claimed_o = claimed_q;

   // The lowest-index target reading a given ID wins; higher ones see 0.
   always_comb begin
      grant   = '0;
      cc_id_o = '0;
      taken   = 1'b0;
      for (int t = 0; t < N_TARGET; t++) begin
         taken = 1'b0;
         for (int j = 0; j < N_TARGET; j++) begin
            if (j < t && cc_re_i[j] && claim_id_i[j] == claim_id_i[t]) taken = 1'b1;
         end
         grant[t] = cc_re_i[t] && !taken && (claim_id_i[t] != '0) &&
                    (claim_id_i[t] <= SRCW'(N_SOURCE)) && ip_q[claim_id_i[t]];
         if (!cc_re_i[t])   cc_id_o[t] = claim_id_i[t];
         else if (grant[t]) cc_id_o[t] = claim_id_i[t];
         else               cc_id_o[t] = '0;
      end
   end

   always_comb begin
      claim_hit = '0;
      cmpl_hit  = '0;
      for (int k = 1; k <= N_SOURCE; k++) begin
         for (int t = 0; t < N_TARGET; t++) begin
            if (grant[t]   && claim_id_i[t] == SRCW'(k)) claim_hit[k] = 1'b1;
            if (cc_we_i[t] && cc_i[t]       == SRCW'(k)) cmpl_hit[k]  = 1'b1;
         end
      end
   end

   always_comb begin
      ip_d      = '0;
      claimed_d = '0;
      for (int k = 1; k <= N_SOURCE; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         case (state_q[k])
            IDLE: begin
               if (le_i[k-1]) begin
                  // A fresh edge is used directly; otherwise drain one queued edge.
                  if (rise[k-1]) begin
                     state_d[k] = PEND;
                  end else if (cnt_q[k] != '0) begin
                     state_d[k] = PEND;
                     cnt_d[k]   = cnt_q[k] - 1'b1;
                  end
               end else if (irq_i[k-1]) begin
                  state_d[k] = PEND;
               end
            end
            PEND: begin
               if (claim_hit[k]) state_d[k] = CLAIMED;
               if (rise[k-1] && cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + 1'b1;
            end
            CLAIMED: begin
               if (cmpl_hit[k]) state_d[k] = IDLE;
               if (rise[k-1] && cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + 1'b1;
            end
            default: state_d[k] = IDLE;
         endcase
         if (!le_i[k-1]) cnt_d[k] = '0;
         ip_d[k]      = (state_d[k] == PEND);
         claimed_d[k] = (state_d[k] == CLAIMED);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_q     <= '0;
         ip_q      <= '0;
         claimed_q <= '0;
         for (int k = 1; k <= N_SOURCE; k++) begin
            state_q[k] <= IDLE;
            cnt_q[k]   <= '0;
         end
      end else begin
         irq_q     <= irq_i;
         ip_q      <= ip_d;
         claimed_q <= claimed_d;
         for (int k = 1; k <= N_SOURCE; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

endmodule

// File: tb/tb_plic_gateway_ctrl.sv
// Directed bench for plic_gateway_ctrl: level/edge gateways, claim arbitration,
// complete filtering and asynchronous reset.
module tb_plic_gateway_ctrl;

   localparam int NS = 128;
   localparam int NT = 60;
   localparam int SW = 8;

   logic                   clk;
   logic                   rst;
   logic [NS-1:0]          irq;
   logic [NS-1:0]          le;
   logic [NS:0]            ip;
   logic [NS:0]            claimed;
   logic [NT-1:0][SW-1:0]  claim_id;
   logic [NT-1:0]          cc_re;
   logic [NT-1:0][SW-1:0]  cc_id;
   logic [NT-1:0]          cc_we;
   logic [NT-1:0][SW-1:0]  cc;

   int n_chk;
   int n_fail;

   plic_gateway_ctrl #(.N_SOURCE(NS), .N_TARGET(NT), .SRCW(SW), .EDGE_CNTW(2)) dut (
      .clk_i(clk), .rst_i(rst), .irq_i(irq), .le_i(le), .ip_o(ip), .claimed_o(claimed),
      .claim_id_i(claim_id), .cc_re_i(cc_re), .cc_id_o(cc_id), .cc_we_i(cc_we), .cc_i(cc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1ns after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_bus();
      cc_re = '0;
      cc_we = '0;
      claim_id = '0;
      cc = '0;
   endtask

   task automatic do_claim(input int t, input int id);
      cc_re[t] = 1'b1;
      claim_id[t] = SW'(id);
      step();
      clear_bus();
   endtask

   task automatic do_cmpl(input int t, input int id);
      cc_we[t] = 1'b1;
      cc[t] = SW'(id);
      step();
      clear_bus();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      irq = '0;
      le = '0;
      clear_bus();
      #2;
      n_chk++; if (ip !== '0) begin n_fail++; $display("FAIL rst_ip: ip_o=%h required 0", ip); end
      n_chk++; if (claimed !== '0) begin n_fail++; $display("FAIL rst_claimed: claimed_o=%h required 0", claimed); end
      claim_id[3] = 8'd7;
      #1;
      n_chk++; if (cc_id[3] !== 8'd7) begin n_fail++; $display("FAIL preview: cc_id_o[3]=%0d required 7", cc_id[3]); end
      claim_id[3] = '0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_level();
      irq[4] = 1'b1;
      step();
      n_chk++; if (ip[5] !== 1'b1) begin n_fail++; $display("FAIL lvl_pend: ip_o[5]=%0b required 1", ip[5]); end
      cc_re[0] = 1'b1;
      claim_id[0] = 8'd5;
      #1;
      n_chk++; if (cc_id[0] !== 8'd5) begin n_fail++; $display("FAIL lvl_claim: cc_id_o[0]=%0d required 5", cc_id[0]); end
      step();
      clear_bus();
      n_chk++; if (ip[5] !== 1'b0 || claimed[5] !== 1'b1) begin n_fail++; $display("FAIL lvl_claimed: ip=%0b claimed=%0b required 0/1", ip[5], claimed[5]); end
      do_cmpl(0, 5);
      n_chk++; if (ip[5] !== 1'b0 || claimed[5] !== 1'b0) begin n_fail++; $display("FAIL lvl_idle: ip=%0b claimed=%0b required 0/0", ip[5], claimed[5]); end
      step();
      n_chk++; if (ip[5] !== 1'b1) begin n_fail++; $display("FAIL lvl_repend: ip_o[5]=%0b required 1", ip[5]); end
      irq[4] = 1'b0;
      step();
      n_chk++; if (ip[5] !== 1'b1) begin n_fail++; $display("FAIL lvl_hold: ip_o[5]=%0b required 1", ip[5]); end
      do_claim(0, 5);
      do_cmpl(0, 5);
      step();
      n_chk++; if (ip[5] !== 1'b0 || claimed[5] !== 1'b0) begin n_fail++; $display("FAIL lvl_done: ip=%0b claimed=%0b required 0/0", ip[5], claimed[5]); end
   endtask

   task automatic test_edge_count();
      le[2] = 1'b1;
      irq[2] = 1'b0;
      step();
      irq[2] = 1'b1;
      step();
      n_chk++; if (ip[3] !== 1'b1) begin n_fail++; $display("FAIL edge_pend: ip_o[3]=%0b required 1", ip[3]); end
      do_claim(0, 3);
      n_chk++; if (claimed[3] !== 1'b1) begin n_fail++; $display("FAIL edge_claimed: claimed_o[3]=%0b required 1", claimed[3]); end
      // Five edges while in service; the 2-bit queue keeps only three.
      for (int i = 0; i < 5; i++) begin
         irq[2] = 1'b0;
         step();
         irq[2] = 1'b1;
         step();
      end
      for (int r = 0; r < 3; r++) begin
         do_cmpl(0, 3);
         n_chk++; if (claimed[3] !== 1'b0) begin n_fail++; $display("FAIL edge_cmpl%0d: claimed_o[3]=%0b required 0", r, claimed[3]); end
         step();
         n_chk++; if (ip[3] !== 1'b1) begin n_fail++; $display("FAIL edge_repend%0d: ip_o[3]=%0b required 1", r, ip[3]); end
         do_claim(0, 3);
      end
      do_cmpl(0, 3);
      step();
      step();
      n_chk++; if (ip[3] !== 1'b0 || claimed[3] !== 1'b0) begin n_fail++; $display("FAIL edge_sat: ip=%0b claimed=%0b required 0/0", ip[3], claimed[3]); end
      irq[2] = 1'b0;
      step();
   endtask

   task automatic test_simul_claim();
      irq[8] = 1'b1;
      step();
      cc_re[2] = 1'b1;
      cc_re[7] = 1'b1;
      claim_id[2] = 8'd9;
      claim_id[7] = 8'd9;
      #1;
      n_chk++; if (cc_id[2] !== 8'd9) begin n_fail++; $display("FAIL sim_win: cc_id_o[2]=%0d required 9", cc_id[2]); end
      n_chk++; if (cc_id[7] !== 8'd0) begin n_fail++; $display("FAIL sim_lose: cc_id_o[7]=%0d required 0", cc_id[7]); end
      step();
      clear_bus();
      n_chk++; if (claimed[9] !== 1'b1 || ip[9] !== 1'b0) begin n_fail++; $display("FAIL sim_state: claimed=%0b ip=%0b required 1/0", claimed[9], ip[9]); end
      cc_re[7] = 1'b1;
      claim_id[7] = 8'd9;
      #1;
      n_chk++; if (cc_id[7] !== 8'd0) begin n_fail++; $display("FAIL sim_reclaim: cc_id_o[7]=%0d required 0", cc_id[7]); end
      clear_bus();
      irq[8] = 1'b0;
      do_cmpl(2, 9);
      step();
      n_chk++; if (claimed[9] !== 1'b0 || ip[9] !== 1'b0) begin n_fail++; $display("FAIL sim_done: claimed=%0b ip=%0b required 0/0", claimed[9], ip[9]); end
   endtask

   task automatic test_invalid_complete();
      logic [NS:0] exp_ip;
      logic [NS:0] exp_cl;
      int bad_id[3];
      exp_ip = '0;
      exp_cl = '0;
      exp_ip[11] = 1'b1;
      exp_cl[10] = 1'b1;
      bad_id[0] = 0;
      bad_id[1] = NS + 1;
      bad_id[2] = 11;
      irq[9] = 1'b1;
      irq[10] = 1'b1;
      step();
      do_claim(0, 10);
      n_chk++; if (ip !== exp_ip || claimed !== exp_cl) begin n_fail++; $display("FAIL inv_setup: ip=%h claimed=%h required %h/%h", ip, claimed, exp_ip, exp_cl); end
      for (int i = 0; i < 3; i++) begin
         do_cmpl(3, bad_id[i]);
         step();
         n_chk++; if (ip !== exp_ip) begin n_fail++; $display("FAIL inv_ip id=%0d: ip=%h required %h", bad_id[i], ip, exp_ip); end
         n_chk++; if (claimed !== exp_cl) begin n_fail++; $display("FAIL inv_cl id=%0d: claimed=%h required %h", bad_id[i], claimed, exp_cl); end
      end
      // Complete 10 and claim 11 in the same cycle.
      irq[9] = 1'b0;
      irq[10] = 1'b0;
      cc_we[0] = 1'b1;
      cc[0] = 8'd10;
      cc_re[1] = 1'b1;
      claim_id[1] = 8'd11;
      step();
      clear_bus();
      exp_cl = '0;
      exp_cl[11] = 1'b1;
      n_chk++; if (ip !== '0 || claimed !== exp_cl) begin n_fail++; $display("FAIL inv_mixed: ip=%h claimed=%h required 0/%h", ip, claimed, exp_cl); end
      do_cmpl(0, 11);
      n_chk++; if (claimed !== '0) begin n_fail++; $display("FAIL inv_clean: claimed=%h required 0", claimed); end
   endtask

   task automatic test_dual_complete();
      irq[11] = 1'b1;
      step();
      do_claim(5, 12);
      n_chk++; if (claimed[12] !== 1'b1) begin n_fail++; $display("FAIL dual_claimed: claimed_o[12]=%0b required 1", claimed[12]); end
      irq[11] = 1'b0;
      cc_we[1] = 1'b1;
      cc_we[4] = 1'b1;
      cc[1] = 8'd12;
      cc[4] = 8'd12;
      step();
      clear_bus();
      n_chk++; if (claimed[12] !== 1'b0 || ip[12] !== 1'b0) begin n_fail++; $display("FAIL dual_idle: claimed=%0b ip=%0b required 0/0", claimed[12], ip[12]); end
      step();
      n_chk++; if (ip[12] !== 1'b0) begin n_fail++; $display("FAIL dual_norepend: ip_o[12]=%0b required 0", ip[12]); end
   endtask

   task automatic test_reset_mid();
      le[5] = 1'b1;
      irq[5] = 1'b0;
      step();
      irq[5] = 1'b1;
      step();
      do_claim(0, 6);
      for (int i = 0; i < 2; i++) begin
         irq[5] = 1'b0;
         step();
         irq[5] = 1'b1;
         step();
      end
      irq[5] = 1'b0;
      step();
      n_chk++; if (claimed[6] !== 1'b1) begin n_fail++; $display("FAIL rmid_claimed: claimed_o[6]=%0b required 1", claimed[6]); end
      #2;
      rst = 1'b1;
      #1;
      n_chk++; if (ip !== '0 || claimed !== '0) begin n_fail++; $display("FAIL rmid_async: ip=%h claimed=%h required 0/0", ip, claimed); end
      #1;
      rst = 1'b0;
      step();
      do_cmpl(0, 6);
      step();
      step();
      n_chk++; if (claimed[6] !== 1'b0 || ip[6] !== 1'b0) begin n_fail++; $display("FAIL rmid_after: claimed=%0b ip=%0b required 0/0", claimed[6], ip[6]); end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      test_reset();
      test_level();
      test_edge_count();
      test_simul_claim();
      test_invalid_complete();
      test_dual_complete();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/plic_gateway_ctrl.md
Name: plic_gateway_ctrl

Overview:
Per-source interrupt gateway and claim/complete sequencer for the PLIC.
- Converts raw level/edge interrupt lines into pending bits, which drive the register map's ip_i.
- Sequences each source through pending -> claimed -> completed.
- Resolves simultaneous claims from multiple targets and returns the granted claim ID to the register map's cc_i.
- Sits between the external interrupt lines, the per-target max-priority selectors (which supply the best ID per target) and plic_regs.

Parameters:
N_SOURCE, 128, number of interrupt sources; source 0 is reserved.
N_TARGET, 60, number of interrupt targets (contexts).
SRCW, $clog2(N_SOURCE+1), width of a source ID.
EDGE_CNTW, 2, width of the per-source saturating count of queued edge requests.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
irq_i  in  N_SOURCE  raw interrupt lines; bit k-1 is source k
le_i  in  N_SOURCE  trigger mode per source: 1 = rising edge, 0 = level-high
ip_o  out  N_SOURCE+1  pending bits; bit 0 is constant 0, bit k is source k
claimed_o  out  N_SOURCE+1  source in service; bit 0 is constant 0
claim_id_i  in  N_TARGET x SRCW  best pending+enabled source per target; 0 means none
cc_re_i  in  N_TARGET  claim read strobe from the register map
cc_id_o  out  N_TARGET x SRCW  claim response data, goes to the register map's cc_i
cc_we_i  in  N_TARGET  complete write strobe from the register map
cc_i  in  N_TARGET x SRCW  completed source ID written by each target

Behaviour:
- Per-source FSM with states IDLE, PEND and CLAIMED.
  - ip_o[k] = (state==PEND).
  - claimed_o[k] = (state==CLAIMED).
- Reset is asynchronous on rst_i:
  - all sources go to IDLE;
  - edge counters and the irq_i sample register clear to 0;
  - ip_o and claimed_o are 0.
- Edge detection: irq_q <= irq_i every cycle. rise[k] = irq_i & ~irq_q, qualified by le_i[k].
- IDLE -> PEND:
  - Level mode: when irq_i[k]=1.
  - Edge mode: when rise[k]=1 or cnt[k]>0.
  - ip_o rises 1 cycle after the triggering sample.
- Edge counter cnt[k]:
  - +1 on rise, saturating at 2^EDGE_CNTW-1; further edges are dropped.
  - -1 when the counter supplies an IDLE->PEND transition.
  - rise in IDLE goes straight to PEND with no net change to cnt.
  - rise plus a consume in the same cycle gives no net change.
  - Forced to 0 whenever le_i[k]=0.
- PEND -> CLAIMED: on a granted claim of ID k (see arbitration). ip_o[k] falls the next cycle.
- CLAIMED -> IDLE: when any target has cc_we_i[t]=1 and cc_i[t]=k.
  - Completes from several targets in one cycle count as a single complete.
  - Level mode: if irq_i is still high, the source re-enters PEND one cycle later.
- Completes are ignored, with no state change, when:
  - the ID is 0;
  - the ID is greater than N_SOURCE;
  - the source is not in CLAIMED.
- PEND is never lost by irq_i deasserting: gateway semantics hold the request.
- Claim arbitration (combinational, same cycle as cc_re_i):
  - Target t is granted iff all of the following hold:
    - cc_re_i[t]=1;
    - id = claim_id_i[t] is in 1..N_SOURCE;
    - source id is in PEND;
    - no lower-index target j has cc_re_i[j]=1 with claim_id_i[j]=id.
  - cc_id_o[t] = id if granted, else 0.
  - When cc_re_i[t]=0, cc_id_o[t] = claim_id_i[t] (preview value, no side effect).
  - A losing target reads 0, which software treats as a spurious claim.
- A claim and a complete of the same source in one cycle cannot both apply: the states differ. The state decides which one takes effect.
- Different sources can be claimed and completed in the same cycle independently.
- Reset asserted mid-operation aborts all claims. Completes arriving after reset are ignored because no source is in CLAIMED.

Test Plan:
- Level source 5: irq_i[4]=1 at cycle 0 -> ip_o[5]=1 at cycle 1; target 0 claim with claim_id_i[0]=5 -> cc_id_o[0]=5, ip_o[5]=0 and claimed_o[5]=1 next cycle; complete 5 while irq is still high -> PEND again 2 cycles after the complete.
- Edge source 3 (le_i[2]=1): 3 rising edges while CLAIMED with EDGE_CNTW=2 -> cnt=3; complete -> PEND next cycle and cnt=2; a 4th and 5th edge with cnt=3 are dropped (saturation).
- Simultaneous claim: targets 2 and 7 both set cc_re_i with claim_id_i=9 -> cc_id_o[2]=9, cc_id_o[7]=0, source 9 CLAIMED once.
- Invalid complete: cc_i=0, cc_i=N_SOURCE+1, or an ID in PEND -> no state change in any source.
- Dual complete: targets 1 and 4 complete ID 12 in the same cycle -> source 12 goes IDLE once, with no error and no double re-pend.
- Reset: rst_i pulsed asynchronously mid-cycle with source 6 CLAIMED and cnt[6]=2 -> immediately ip_o=0, claimed_o=0, cnt=0; a subsequent complete of 6 is ignored.
